// File: rtl/fix_msg_fifo_if.sv
// Bundle of the write (engine) and read (peer) signals of fix_msg_fifo.
// slave: the FIFO itself. master: whoever drives the engine side and accepts bytes.
interface fix_msg_fifo_if #(
    parameter int unsigned MAX_MSGS = 8
);
    localparam int unsigned CW = $clog2(MAX_MSGS) + 1;

    logic          wr_en_i;
    logic [7:0]    wr_data_i;
    logic          wr_end_i;
    logic          full_o;
    logic          overflow_o;
    logic          new_message_o;
    logic [7:0]    rd_data_o;
    logic          rd_valid_o;
    logic          rd_last_o;
    logic          rd_ready_i;
    logic [CW-1:0] msg_count_o;

    modport slave (
        input  wr_en_i, wr_data_i, wr_end_i, rd_ready_i,
        output full_o, overflow_o, new_message_o, rd_data_o, rd_valid_o, rd_last_o,
               msg_count_o
    );

    modport master (
        output wr_en_i, wr_data_i, wr_end_i, rd_ready_i,
        input  full_o, overflow_o, new_message_o, rd_data_o, rd_valid_o, rd_last_o,
               msg_count_o
    );
endinterface

// File: rtl/fix_msg_fifo.sv
// Message-framed byte FIFO: stores engine bytes, commits a message only on its end
// strobe, and replays each committed message as a new_message pulse plus a byte
// stream with backpressure. Dropped (overflowed) messages are never forwarded.
// Optional: define FIX_MSG_FIFO_STRIP_EN to discard the first byte of every message.
module fix_msg_fifo #(
    parameter int unsigned DEPTH    = 512,
    parameter int unsigned AW       = 9,
    parameter int unsigned MAX_MSGS = 8
) (
    input  logic          clk,
    input  logic          rst,
    fix_msg_fifo_if.slave bus
);
    localparam int unsigned QW = $clog2(MAX_MSGS);

    typedef logic [AW:0] ptr_t;
    typedef logic [QW:0] qptr_t;
    typedef enum logic [1:0] {StIdle, StAnnounce, StStream, StGap} state_e;

    logic [7:0] mem_q     [DEPTH];
    ptr_t       len_mem_q [MAX_MSGS];

    ptr_t   wr_ptr_q, wr_ptr_d, commit_ptr_q, commit_ptr_d;
    ptr_t   rd_ptr_q, rd_ptr_d, rem_q, rem_d;
    qptr_t  qw_q, qr_q, q_count;
    logic   drop_q, drop_d, ovf_q, ovf_d;
    state_e state_q, state_d;
`ifdef FIX_MSG_FIFO_STRIP_EN
    logic   first_q, first_d;
`endif

    logic   store_full, queue_full, byte_take, drop_now, mem_we, push, pop;
    ptr_t   wr_ptr_adv, msg_len;
    logic   new_msg, rd_valid, rd_last;
    logic [7:0] rd_data;

    assign q_count    = qw_q - qr_q;
    assign store_full = (wr_ptr_q - rd_ptr_q) == ptr_t'(DEPTH);
    assign queue_full = q_count == qptr_t'(MAX_MSGS);

    // Write side: accept bytes, detect overflow, commit or roll back on end strobe.
    always_comb begin
        wr_ptr_adv   = wr_ptr_q;
        commit_ptr_d = commit_ptr_q;
        drop_d       = drop_q;
        ovf_d        = 1'b0;
        mem_we       = 1'b0;
        push         = 1'b0;
`ifdef FIX_MSG_FIFO_STRIP_EN
        first_d   = first_q;
        byte_take = bus.wr_en_i && !drop_q && !first_q;
        if (bus.wr_en_i && !drop_q) begin
            first_d = 1'b0;
        end
`else
        byte_take = bus.wr_en_i && !drop_q;
`endif
        if (byte_take) begin
            if (store_full) begin
                drop_d = 1'b1;
            end else begin
                mem_we     = 1'b1;
                wr_ptr_adv = wr_ptr_q + 1'b1;
            end
        end
        drop_now = drop_q || (byte_take && store_full);
        wr_ptr_d = wr_ptr_adv;
        // Length includes a byte that arrives together with the end strobe.
        msg_len  = wr_ptr_adv - commit_ptr_q;
        if (bus.wr_end_i) begin
`ifdef FIX_MSG_FIFO_STRIP_EN
            first_d = 1'b1;
`endif
            drop_d = 1'b0;
            if (drop_now || (msg_len != '0 && queue_full)) begin
                wr_ptr_d = commit_ptr_q;
                ovf_d    = 1'b1;
            end else if (msg_len != '0) begin
                push         = 1'b1;
                commit_ptr_d = wr_ptr_adv;
            end
        end
    end

    // Read FSM: announce, stream the head message, then one gap cycle.
    always_comb begin
        state_d  = state_q;
        rd_ptr_d = rd_ptr_q;
        rem_d    = rem_q;
        pop      = 1'b0;
        new_msg  = 1'b0;
        rd_valid = 1'b0;
        rd_last  = 1'b0;
        rd_data  = 8'h00;
        unique case (state_q)
            StIdle: begin
                if (q_count != '0) state_d = StAnnounce;
            end
            StAnnounce: begin
                new_msg = 1'b1;
                rem_d   = len_mem_q[qr_q[QW-1:0]];
                state_d = StStream;
            end
            StStream: begin
                rd_valid = 1'b1;
                rd_data  = mem_q[rd_ptr_q[AW-1:0]];
                rd_last  = rem_q == ptr_t'(1);
                if (bus.rd_ready_i) begin
                    rd_ptr_d = rd_ptr_q + 1'b1;
                    rem_d    = rem_q - 1'b1;
                    if (rem_q == ptr_t'(1)) begin
                        pop     = 1'b1;
                        state_d = StGap;
                    end
                end
            end
            StGap: begin
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Control state with synchronous reset; reset discards all stored messages.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            commit_ptr_q <= '0;
            rd_ptr_q     <= '0;
            rem_q        <= '0;
            qw_q         <= '0;
            qr_q         <= '0;
            drop_q       <= 1'b0;
            ovf_q        <= 1'b0;
            state_q      <= StIdle;
`ifdef FIX_MSG_FIFO_STRIP_EN
            first_q      <= 1'b1;
`endif
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            commit_ptr_q <= commit_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            rem_q        <= rem_d;
            qw_q         <= qw_q + qptr_t'(push);
            qr_q         <= qr_q + qptr_t'(pop);
            drop_q       <= drop_d;
            ovf_q        <= ovf_d;
            state_q      <= state_d;
`ifdef FIX_MSG_FIFO_STRIP_EN
            first_q      <= first_d;
`endif
        end
    end

    // Byte and length storage; contents are meaningless until pointers cover them.
    always_ff @(posedge clk) begin
        if (mem_we && !rst) mem_q[wr_ptr_q[AW-1:0]] <= bus.wr_data_i;
        if (push && !rst)   len_mem_q[qw_q[QW-1:0]] <= msg_len;
    end

    assign bus.full_o        = store_full || queue_full;
    assign bus.overflow_o    = ovf_q;
    assign bus.new_message_o = new_msg;
    assign bus.rd_valid_o    = rd_valid;
    assign bus.rd_last_o     = rd_last;
    assign bus.rd_data_o     = rd_data;
    assign bus.msg_count_o   = q_count;
endmodule

// File: tb/tb_fix_msg_fifo.sv
// Scoreboard bench for fix_msg_fifo (DEPTH=16). Expected bytes are queued when a
// message is written; a negedge monitor compares every presented byte to the head.
module tb_fix_msg_fifo;
    localparam int unsigned DEPTH = 16, AW = 4, MAX_MSGS = 8;
`ifdef FIX_MSG_FIFO_STRIP_EN
    localparam int S = 1;
`else
    localparam int S = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    fix_msg_fifo_if #(.MAX_MSGS(MAX_MSGS)) bus ();

    fix_msg_fifo #(.DEPTH(DEPTH), .AW(AW), .MAX_MSGS(MAX_MSGS)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int ann_cnt  = 0;
    int ovf_cnt  = 0;
    int pop_cnt  = 0;
    logic [8:0] exp_q[$];
    logic [7:0] msg_buf[32];

    task automatic check(input string name, input int got, input int want);
        n_checks++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, got, got, want, want);
        end
    endtask

    // Monitor: every cycle a byte is presented it must match the scoreboard head.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.new_message_o) ann_cnt++;
            if (bus.overflow_o) ovf_cnt++;
            if (bus.rd_valid_o) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_byte: got 0x%0h, expected no byte", bus.rd_data_o);
                end else begin
                    check("rd_byte", int'({bus.rd_last_o, bus.rd_data_o}), int'(exp_q[0]));
                    if (bus.rd_ready_i) begin
                        void'(exp_q.pop_front());
                        pop_cnt++;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int n, input bit deliver);
        if (deliver) begin
            for (int i = S; i < n; i++) exp_q.push_back({(i == n - 1), msg_buf[i]});
        end
        for (int i = 0; i < n; i++) begin
            bus.wr_en_i   = 1'b1;
            bus.wr_data_i = msg_buf[i];
            bus.wr_end_i  = (i == n - 1);
            tick();
        end
        bus.wr_en_i  = 1'b0;
        bus.wr_end_i = 1'b0;
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (exp_q.size() == 0 && bus.msg_count_o == 0 && !bus.rd_valid_o) break;
            tick();
        end
        check("drain_left", exp_q.size(), 0);
        check("drain_msg_count", int'(bus.msg_count_o), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_full"}, int'(bus.full_o), 0);
        check({tag, "_overflow"}, int'(bus.overflow_o), 0);
        check({tag, "_new_message"}, int'(bus.new_message_o), 0);
        check({tag, "_rd_valid"}, int'(bus.rd_valid_o), 0);
        check({tag, "_rd_last"}, int'(bus.rd_last_o), 0);
        check({tag, "_rd_data"}, int'(bus.rd_data_o), 0);
        check({tag, "_msg_count"}, int'(bus.msg_count_o), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0, o0, p0, len;
        bus.wr_en_i    = 1'b0;
        bus.wr_data_i  = 8'h00;
        bus.wr_end_i   = 1'b0;
        bus.rd_ready_i = 1'b1;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check_reset_outputs("reset");

        // Single message with latency checks.
        msg_buf[0] = 8'h38; msg_buf[1] = "8"; msg_buf[2] = "=";
        msg_buf[3] = "F";   msg_buf[4] = "I";
        a0 = ann_cnt; p0 = pop_cnt;
        send(5, 1'b1);
        check("single_count_after_end", int'(bus.msg_count_o), 1);
        check("single_no_announce_yet", int'(bus.new_message_o), 0);
        tick();
        check("single_announce", int'(bus.new_message_o), 1);
        tick();
        check("single_first_valid", int'(bus.rd_valid_o), 1);
        check("single_first_data", int'(bus.rd_data_o), int'(msg_buf[S]));
        drain(50);
        check("single_ann_count", ann_cnt - a0, 1);
        check("single_bytes", pop_cnt - p0, 5 - S);

        // Backpressure: ready pattern 1,0,0,1,0,0,...
        a0 = ann_cnt; p0 = pop_cnt;
        bus.rd_ready_i = 1'b0;
        send(5, 1'b1);
        for (int c = 0; c < 60; c++) begin
            if (exp_q.size() == 0) break;
            bus.rd_ready_i = (c % 3 == 0);
            tick();
        end
        bus.rd_ready_i = 1'b1;
        drain(20);
        check("bp_bytes", pop_cnt - p0, 5 - S);
        check("bp_ann_count", ann_cnt - a0, 1);

        // Overflow: 20-byte message into 16 bytes of storage.
        a0 = ann_cnt; o0 = ovf_cnt;
        for (int i = 0; i < 20; i++) begin
            bus.wr_en_i   = 1'b1;
            bus.wr_data_i = 8'(i);
            bus.wr_end_i  = (i == 19);
            tick();
            if (i < 19) check($sformatf("ovf_full_%0d", i), int'(bus.full_o), int'((i + 1 - S) >= 16));
        end
        bus.wr_en_i = 1'b0; bus.wr_end_i = 1'b0;
        check("ovf_full_released", int'(bus.full_o), 0);
        for (int i = 0; i < 4; i++) tick();
        check("ovf_pulses", ovf_cnt - o0, 1);
        check("ovf_no_announce", ann_cnt - a0, 0);
        check("ovf_msg_count", int'(bus.msg_count_o), 0);
        msg_buf[0] = "x"; msg_buf[1] = "y"; msg_buf[2] = "z";
        send(3, 1'b1);
        drain(50);
        check("ovf_next_msg_ann", ann_cnt - a0, 1);

        // Queue full: eight committed messages with ready held low.
        a0 = ann_cnt; o0 = ovf_cnt;
        len = 2 + S;
        bus.rd_ready_i = 1'b0;
        for (int m = 0; m < 8; m++) begin
            for (int j = 0; j < len; j++) msg_buf[j] = 8'(m * 16 + j + 1);
            send(len, 1'b1);
        end
        check("qf_full", int'(bus.full_o), 1);
        check("qf_msg_count", int'(bus.msg_count_o), 8);
        for (int j = 0; j < len; j++) msg_buf[j] = 8'hE0 + 8'(j);
        send(len, 1'b0);
        for (int i = 0; i < 3; i++) tick();
        check("qf_overflow", ovf_cnt - o0, 1);
        check("qf_count_kept", int'(bus.msg_count_o), 8);
        bus.rd_ready_i = 1'b1;
        drain(200);
        check("qf_ann_count", ann_cnt - a0, 8);

        // Reset in the middle of streaming a 10-byte message.
        for (int j = 0; j < 10; j++) msg_buf[j] = 8'hA0 + 8'(j);
        send(10, 1'b1);
        for (int i = 0; i < 10; i++) begin
            if (bus.rd_valid_o) break;
            tick();
        end
        tick();
        tick();
        check("rst_streaming_before", int'(bus.rd_valid_o), 1);
        exp_q.delete();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_outputs("rst_mid");
        a0 = ann_cnt;
        msg_buf[0] = 8'h51; msg_buf[1] = 8'h52; msg_buf[2] = 8'h53;
        send(3, 1'b1);
        drain(50);
        check("rst_next_msg_ann", ann_cnt - a0, 1);

        // End strobe with no bytes is ignored.
        a0 = ann_cnt; o0 = ovf_cnt;
        bus.wr_end_i = 1'b1;
        tick();
        bus.wr_end_i = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("zero_len_ann", ann_cnt - a0, 0);
        check("zero_len_ovf", ovf_cnt - o0, 0);
        check("zero_len_count", int'(bus.msg_count_o), 0);

`ifdef FIX_MSG_FIFO_STRIP_EN
        // Header byte stripped; a header-only message disappears.
        a0 = ann_cnt; p0 = pop_cnt;
        msg_buf[0] = 8'h08; msg_buf[1] = "A"; msg_buf[2] = "B";
        send(3, 1'b1);
        drain(50);
        check("strip_ann", ann_cnt - a0, 1);
        check("strip_bytes", pop_cnt - p0, 2);
        a0 = ann_cnt; o0 = ovf_cnt;
        msg_buf[0] = 8'h08;
        send(1, 1'b0);
        for (int i = 0; i < 4; i++) tick();
        check("strip_lone_ann", ann_cnt - a0, 0);
        check("strip_lone_ovf", ovf_cnt - o0, 0);
        check("strip_lone_count", int'(bus.msg_count_o), 0);
`endif

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end
endmodule

// File: doc/fix_msg_fifo.md
# fix_msg_fifo

Message-framed byte FIFO between a FIX engine's outbound byte stream and the peer side's inbound message port. Captures bytes from the engine's `fifo_write`/`message`/`end` outputs, commits whole messages only on the end strobe, and replays each committed message as a `new_message` pulse followed by a byte stream with backpressure. Partial or overflowed messages are never forwarded. One instance per direction: initiator→acceptor and acceptor→initiator.

## Interface
- `DEPTH`, 512: byte storage; must be a power of 2.
- `AW`, 9: log2(DEPTH).
- `MAX_MSGS`, 8: committed-message length queue entries; must be a power of 2.

Clock and reset: one clock; reset is synchronous and active-high.

- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `wr_en_i`  in  1  byte strobe from the engine (`fifo_write_*_o`).
- `wr_data_i`  in  8  byte from the engine (`message_*_o`).
- `wr_end_i`  in  1  end-of-message strobe (`end_*_o`). It may coincide with a final `wr_en_i`; in that case the byte belongs to the message.
- `full_o`  out  1  backpressure to the engine (`fifo_full_*_i`).
- `overflow_o`  out  1  one-cycle pulse when a message is dropped.
- `new_message_o`  out  1  one-cycle pulse announcing a message; goes to the peer `new_message_*_i`.
- `rd_data_o`  out  8  message byte; goes to the peer `message_*_i`.
- `rd_valid_o`  out  1  `rd_data_o` is valid.
- `rd_last_o`  out  1  the current byte is the last byte of the message.
- `rd_ready_i`  in  1  downstream accepts the byte.
- `msg_count_o`  out  AW-bits is not used; width is log2(MAX_MSGS)+1. Number of committed, unsent messages.

## Operation
**Write side**
- `wr_ptr` advances on each accepted byte.
- `commit_ptr` marks the start of the open message.
- On `wr_end_i`, length = `wr_ptr - commit_ptr` (including any coincident byte). The length is pushed to the length queue and `commit_ptr` ← `wr_ptr`.
- Zero-length message (end with no bytes): ignored, with no push and no pulse.
- Byte written while storage is full, or `wr_end_i` while the length queue is full:
  - set `drop`;
  - ignore further bytes until `wr_end_i`;
  - at `wr_end_i`, `wr_ptr` ← `commit_ptr` and `overflow_o` pulses.

**`full_o` (combinational from registers)**
- Asserted when (`wr_ptr - rd_ptr`) == DEPTH, or when the length queue holds MAX_MSGS entries.

**Read FSM**
- IDLE → ANNOUNCE when `msg_count_o` > 0.
- ANNOUNCE: `new_message_o` = 1 for one cycle; load `remaining` from the queue head; go to STREAM.
- STREAM: `rd_valid_o` = 1 and `rd_data_o` = `mem[rd_ptr]`.
  - `rd_last_o` = (`remaining` == 1).
  - Each cycle with `rd_ready_i` = 1: `rd_ptr`++ and `remaining`--.
  - On the last byte accepted: pop the length queue and go to GAP.
- GAP: one idle cycle, then IDLE.
- Back-to-back messages are separated by exactly GAP + IDLE + ANNOUNCE.

**Arithmetic**
- Pointers are AW+1 bits, wrapping modulo 2·DEPTH.
- Memory is indexed by `ptr[AW-1:0]`.
- Lengths are AW+1 bits.

## Timing
- Reset values:
  - all pointers 0; queue empty; FSM IDLE; `drop` 0;
  - `full_o` 0, `overflow_o` 0, `new_message_o` 0, `rd_valid_o` 0, `rd_last_o` 0, `rd_data_o` 8'h00, `msg_count_o` 0.
- Reset mid-message or mid-stream discards all contents.
- Latency, with `wr_end_i` sampled at edge N:
  - `msg_count_o` increments after N;
  - FSM enters ANNOUNCE at N+1, so `new_message_o` is high in cycle N+1..N+2;
  - first `rd_valid_o` in cycle N+2..N+3.
- `rd_data_o` is held stable while `rd_valid_o` = 1 and `rd_ready_i` = 0.
- Simultaneous commit and pop: `msg_count_o` is unchanged.
- Simultaneous write and read on the same cycle is allowed. `full_o` reflects pointers after the previous edge.
- The engine must not write while `full_o` = 1. If it does, the drop rule applies.

## Configuration
- `FIX_MSG_FIFO_STRIP_EN` defined:
  - the first byte of every message (engine connect/host header byte) is discarded and does not count toward the length;
  - a message consisting only of that byte is treated as zero-length.
- Undefined: all bytes are stored and forwarded.

## Test plan
- **Single message:** write 5 bytes 8'h38,'8','=','F','I' with `wr_end_i` on the last byte, `rd_ready_i` = 1.
  - Expect one `new_message_o` pulse 2 cycles after end.
  - Then 5 consecutive valid bytes in order, `rd_last_o` on 'I', and `msg_count_o` returning to 0.
- **Backpressure:** same message, `rd_ready_i` toggling 1,0,0,1,…
  - Each byte is held until accepted.
  - No byte is lost or duplicated; 5 bytes total.
- **Overflow:** DEPTH=16; write a 20-byte message, then end.
  - `full_o` rises after 16 bytes.
  - `overflow_o` pulses once at end; no `new_message_o`; the following 3-byte message is delivered intact.
- **Queue full:** `rd_ready_i` = 0; commit MAX_MSGS 2-byte messages.
  - `full_o` = 1.
  - The 9th message is dropped with `overflow_o`.
  - Releasing ready delivers 8 messages in order.
- **Reset mid-stream:** assert `rst` during STREAM of a 10-byte message.
  - Next cycle: all outputs at reset values and `msg_count_o` = 0.
  - Then a new 3-byte message is delivered normally.
- **Strip (macro on):** write 8'h08 then 'A','B' with end.
  - Delivered message is 'A','B' (length 2).
  - A lone 1-byte message produces no `new_message_o`.
